// File: rtl/touch_pkg.sv
// touch_pkg: register map, event encoding, FSM states and helpers shared by
// the touch-controller I2C target and its line conditioner.
package touch_pkg;

  // Register addresses inside the eight-entry FT6206-style map.
  localparam logic [2:0] REG_TD_STATUS = 3'd2;
  localparam logic [2:0] REG_XH        = 3'd3;
  localparam logic [2:0] REG_XL        = 3'd4;
  localparam logic [2:0] REG_YH        = 3'd5;
  localparam logic [2:0] REG_YL        = 3'd6;
  localparam logic [2:0] REG_ID        = 3'd7;

  localparam logic [7:0] TOUCH_ID = 8'hA5;

  // Touch event code reported in the top bits of register 0x03.
  typedef enum logic [1:0] {
    EV_PRESS = 2'b00,
    EV_LIFT  = 2'b01
  } touch_event_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_IGNORE
  } tgt_state_t;

  // One touch sample as held in the live and shadow copies.
  typedef struct packed {
    logic         down;
    touch_event_t ev;
    logic [11:0]  x;
    logic [11:0]  y;
  } touch_sample_t;

  // Byte visible at a register address for a given sample.
  function automatic logic [7:0] reg_read(input touch_sample_t s, input logic [2:0] addr);
    logic [7:0] d;
    d = 8'h00;
    case (addr)
      REG_TD_STATUS: d = {7'b0, s.down};
      REG_XH:        d = {s.ev, 2'b00, s.x[11:8]};
      REG_XL:        d = s.x[7:0];
      REG_YH:        d = {4'b0, s.y[11:8]};
      REG_YL:        d = s.y[7:0];
      REG_ID:        d = TOUCH_ID;
      default:       d = 8'h00;
    endcase
    return d;
  endfunction

  // Three-sample majority vote used by the optional glitch filter.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: brings SCL and SDA into the clk_in domain and produces
// single-cycle SCL rise/fall and START/STOP pulses plus the SDA level.
// Optional feature: TOUCH_TGT_GLITCH_FILTER_EN adds a 3-sample majority
// filter on both lines after the synchronizer (+2 cycles of edge latency).
module i2c_line_cond
  import touch_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       w_scl;
  logic       w_sda;
  logic       r_scl_prev;
  logic       r_sda_prev;

  // Two-flop synchronizers; idle-high reset so no edge is seen out of reset.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
    end
  end

`ifdef TOUCH_TGT_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist;
  logic [1:0] r_sda_hist;
  logic       r_scl_flt;
  logic       r_sda_flt;

  // Majority of the current and two previous synchronized samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_flt  <= 1'b1;
      r_sda_flt  <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
      r_scl_flt  <= majority3(r_scl_sync[1], r_scl_hist[0], r_scl_hist[1]);
      r_sda_flt  <= majority3(r_sda_sync[1], r_sda_hist[0], r_sda_hist[1]);
    end
  end

  assign w_scl = r_scl_flt;
  assign w_sda = r_sda_flt;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  // Previous conditioned levels for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_prev;
  assign o_scl_fall = ~w_scl & r_scl_prev;
  // START/STOP only count while SCL has been high for two samples.
  assign o_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign o_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

endmodule

// File: rtl/touch_i2c_target.sv
// touch_i2c_target: I2C target emulating an FT6206-style touch controller.
// Holds the latest touch point, raises an active-low IRQ on new points and
// serves pointer-write / burst-read transactions, driving SDA open-drain.
// Optional feature: TOUCH_TGT_GLITCH_FILTER_EN (see i2c_line_cond).
module touch_i2c_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h38,
  parameter int unsigned CLK_HZ   = 100_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        i2c_irq,
  input  logic        touch_valid_in,
  input  logic        touch_down_in,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  output logic        busy_out
);

  import touch_pkg::*;

  // SCL phases must last at least 4 clk_in cycles at 400 kHz.
  if (CLK_HZ < 3_200_000) begin : g_clk_check
    $error("touch_i2c_target: CLK_HZ too low for 400 kHz SCL");
  end

  logic          w_sda;
  logic          w_scl_rise;
  logic          w_scl_fall;
  logic          w_start;
  logic          w_stop;

  tgt_state_t    r_state,  w_state_nxt;
  logic [3:0]    r_cnt,    w_cnt_nxt;
  logic [6:0]    r_shift,  w_shift_nxt;
  logic [2:0]    r_ptr,    w_ptr_nxt;
  logic          r_rw,     w_rw_nxt;
  logic          r_sda_oe, w_sda_oe_nxt;
  logic          w_copy_shadow;
  logic          w_irq_clear;
  logic          r_irq_n;
  touch_sample_t r_live;
  touch_sample_t r_shadow;
  logic [7:0]    w_rx_byte;
  logic [7:0]    w_tx_byte;

  i2c_line_cond u_line_cond (
    .i_clk      (clk_in),
    .i_rst      (rst_in),
    .i_scl      (scl_in),
    .i_sda      (sda_in),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign w_rx_byte = {r_shift, w_sda};
  assign w_tx_byte = reg_read(r_shadow, r_ptr);

  // Next-state and datapath decode for the transaction FSM.
  // NOTE: every signal gets a default at the top of always_comb; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_shift_nxt   = r_shift;
    w_ptr_nxt     = r_ptr;
    w_rw_nxt      = r_rw;
    w_sda_oe_nxt  = r_sda_oe;
    w_copy_shadow = 1'b0;
    w_irq_clear   = 1'b0;

    if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_sda_oe_nxt = 1'b0;
    end else if (w_start) begin
      // Repeated START keeps the pointer.
      w_state_nxt  = ST_ADDR;
      w_cnt_nxt    = '0;
      w_sda_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_rx_byte[6:0];
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt = '0;
              if (r_state == ST_ADDR) begin
                if (w_rx_byte[7:1] == DEV_ADDR) begin
                  w_state_nxt   = ST_ADDR_ACK;
                  w_rw_nxt      = w_rx_byte[0];
                  w_copy_shadow = w_rx_byte[0];
                end else begin
                  w_state_nxt = ST_IGNORE;
                end
              end else if (r_state == ST_PTR) begin
                w_ptr_nxt   = w_rx_byte[2:0];
                w_state_nxt = ST_PTR_ACK;
              end else begin
                w_ptr_nxt   = r_ptr + 3'd1;
                w_state_nxt = ST_WDATA_ACK;
              end
            end
          end
        end

        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          // First SCL fall drives ACK, the second one ends the slot.
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_cnt_nxt    = '0;
              if (r_state == ST_ADDR_ACK && r_rw) begin
                w_state_nxt  = ST_TX;
                w_shift_nxt  = w_tx_byte[6:0];
                w_sda_oe_nxt = ~w_tx_byte[7];
              end else if (r_state == ST_ADDR_ACK) begin
                w_state_nxt = ST_PTR;
              end else begin
                w_state_nxt = ST_WDATA;
              end
            end
          end
        end

        ST_TX: begin
          if (w_scl_fall) begin
            if (r_cnt == 4'd7) begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = ST_TX_ACK;
            end else begin
              w_cnt_nxt    = r_cnt + 4'd1;
              w_sda_oe_nxt = ~r_shift[6];
              w_shift_nxt  = {r_shift[5:0], 1'b0};
            end
          end
        end

        ST_TX_ACK: begin
          // r_cnt == 8 marks "ACK seen, load next byte on the next fall".
          if (w_scl_rise) begin
            w_irq_clear = (r_ptr == REG_YL);
            if (!w_sda) begin
              w_ptr_nxt = r_ptr + 3'd1;
              w_cnt_nxt = 4'd8;
            end else begin
              w_state_nxt = ST_IGNORE;
            end
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_state_nxt  = ST_TX;
            w_cnt_nxt    = '0;
            w_shift_nxt  = w_tx_byte[6:0];
            w_sda_oe_nxt = ~w_tx_byte[7];
          end
        end

        ST_IGNORE: w_sda_oe_nxt = 1'b0;

        default: ;
      endcase
    end
  end

  // FSM state and datapath registers; reset releases SDA asynchronously.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_ptr    <= '0;
      r_rw     <= 1'b0;
      r_sda_oe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_ptr    <= w_ptr_nxt;
      r_rw     <= w_rw_nxt;
      r_sda_oe <= w_sda_oe_nxt;
    end
  end

  // Live sample, read shadow and interrupt; a new sample beats an IRQ clear.
  // NOTE: the register-map copies are flops, not RAM, so they are reset to
  // zero and read back deterministically before the first touch.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_live   <= '0;
      r_shadow <= '0;
      r_irq_n  <= 1'b1;
    end else begin
      if (touch_valid_in) begin
        r_live.down <= touch_down_in;
        r_live.ev   <= touch_down_in ? EV_PRESS : EV_LIFT;
        r_live.x    <= x_in;
        r_live.y    <= y_in;
      end
      if (w_copy_shadow) begin
        r_shadow <= r_live;
      end
      if (touch_valid_in) begin
        r_irq_n <= 1'b0;
      end else if (w_irq_clear) begin
        r_irq_n <= 1'b1;
      end
    end
  end

  assign sda_oe   = r_sda_oe;
  assign i2c_irq  = r_irq_n;
  assign busy_out = (r_state != ST_IDLE);

endmodule

// File: doc/touch_i2c_target.md
# touch_i2c_target

- Synthesizable I2C target that emulates the capacitive touch controller read by `touchscreen`. It is used as an in-FPGA stand-in for the panel and as a loopback model in simulation.
- It holds the latest touch point in an FT6206-style register map and pulls an active-low interrupt when a new point arrives.
- It answers pointer-write and burst-read transactions from the I2C initiator, driving SDA open-drain.

## Interface
- `DEV_ADDR`, default 7'h38: 7-bit target address.
- `CLK_HZ`, default 100_000_000: system clock frequency. Documentation only; there is no baud dependency.
- `clk_in` in 1: system clock, 100 MHz.
- `rst_in` in 1: asynchronous, active-high reset.
- `scl_in` in 1: I2C clock from the initiator. Asynchronous to `clk_in`.
- `sda_in` in 1: I2C data line as seen at the pad.
- `sda_oe` out 1: 1 pulls SDA low; 0 releases the line to the pull-up.
- `i2c_irq` out 1: interrupt, active low.
- `touch_valid_in` in 1: one-cycle strobe that loads a new touch sample.
- `touch_down_in` in 1: 1 means finger present, 0 means lift.
- `x_in` in 12: touch X coordinate.
- `y_in` in 12: touch Y coordinate.
- `busy_out` in/out direction: out, width 1. High from START to STOP/abort.

## Operation
- **Input conditioning:** SCL and SDA each pass through a 2-flop synchronizer. Edges are detected on the synchronized values.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **Register map:** eight 8-bit registers; pointer is 3 bits and wraps 7→0.
  - 0x00: 0x00.
  - 0x01: 0x00.
  - 0x02: TD_STATUS = {7'b0, down}.
  - 0x03: {event[1:0], 2'b0, x[11:8]}. event = 2'b00 on press, 2'b01 on lift.
  - 0x04: x[7:0].
  - 0x05: {4'b0, y[11:8]}.
  - 0x06: y[7:0].
  - 0x07: 0xA5 (ID).
- **Live and shadow copies:** `touch_valid_in` updates the live copy every time. When a read-address match is ACKed, live is copied to a shadow, and all read bytes of that transaction come from the shadow.
- **FSM states:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, TX, TX_ACK, IGNORE.
  - IDLE→ADDR on START.
  - ADDR: shift 8 bits on SCL rising edges, MSB first. On match go to ADDR_ACK; on mismatch go to IGNORE.
  - ADDR_ACK: drive ACK. If R/W=1 go to TX; else go to PTR.
  - PTR: receive one byte, low 3 bits become the pointer, then ACK.
  - WDATA: further written bytes are ACKed and discarded, and the pointer increments.
  - TX: shift the shadow byte at the pointer. Then TX_ACK samples the initiator's ACK on SCL rise. ACK (0) → pointer+1, next TX byte. NACK → IGNORE.
  - IGNORE: SDA released; wait for STOP or repeated START.
  - STOP in any state → IDLE. START in any state → ADDR (repeated start; pointer preserved).
- **IRQ:**
  - `i2c_irq` goes low on `touch_valid_in`.
  - It returns high after the initiator ACKs or NACKs the byte read from register 0x06 in TX_ACK.
  - A new `touch_valid_in` in the same cycle as that clear wins: IRQ stays low.

## Timing
- Reset values: `sda_oe`=0, `i2c_irq`=1, `busy_out`=0, FSM=IDLE, pointer=0, all live and shadow registers 0.
- SDA is driven or changed only on the cycle after a synchronized SCL falling edge. ACK asserts and the first TX bit appears 3 `clk_in` cycles after the SCL pad falls (2 synchronizer stages + 1 register).
- `sda_oe` is released on the SCL falling edge that ends the ACK slot or last data bit.
- Live registers update on the cycle after `touch_valid_in`. The shadow copy happens on the same cycle ADDR_ACK is entered.
- Minimum SCL high/low time is 4 `clk_in` cycles; 400 kHz I2C is well within this.
- Reset asserted mid-transfer releases SDA immediately (asynchronous) and aborts the transaction.

## Configuration
- `TOUCH_TGT_GLITCH_FILTER_EN` defined: after the synchronizer, SCL and SDA each pass a 3-sample majority filter. This adds 2 cycles to every edge latency, so ACK and TX drive come 5 cycles after the pad SCL falling edge.
- Not defined: no filter; latencies as stated under Timing.

## Structure
- Shared package `touch_pkg`:
  - register address constants (`REG_TD_STATUS`=3'd2 … `REG_ID`=3'd7) and `TOUCH_ID`=8'hA5;
  - the event encoding (`EV_PRESS`, `EV_LIFT`);
  - the FSM state enum `tgt_state_t`.
- One sub-module, `i2c_line_cond`: synchronizer, optional filter, and START/STOP/rise/fall pulse generation. Instantiated once and handles both lines.

## Test plan
- **Basic read.** Stimulus: reset; `touch_valid_in` with down=1, x=12'h2A5, y=12'h13C; write pointer 0x03 to 0x38, then repeated-START read of 4 bytes, NACK on the last. Required: bytes 0x02, 0xA5, 0x01, 0x3C; `i2c_irq` low after the strobe and high after the fourth byte.
- **Address mismatch.** Stimulus: address 0x39 write. Required: no ACK (SDA high in the 9th clock); `sda_oe` stays 0 until STOP.
- **Coherency.** Stimulus: start a read of 0x03–0x06; after byte 1, strobe x=12'hFFF. Required: remaining bytes still reflect x=12'h2A5; the next transaction returns 0x0F/0xFF.
- **Pointer wrap.** Stimulus: pointer 0x07, read 2 bytes. Required: 0xA5 then 0x00.
- **IRQ clear collision.** Stimulus: strobe `touch_valid_in` in the same cycle as the clear from the 0x06 read. Required: `i2c_irq` stays low.
- **Reset mid-ACK.** Stimulus: assert `rst_in` while `sda_oe`=1. Required: `sda_oe`=0 the same cycle; the next START with 0x38 is ACKed normally.
